pipe_hazard_sched: RTL and testbench

//  Scoreboard-based hazard scheduler for the ID stage; it replaces address-compare stall detection.
//  - Tracks pending register writes issued from ID.
//  - Stalls ID on RAW hazards and squashes IF/ID on taken branch/jump.
//  - Sequences a halt/drain so run results are read only after the pipeline is empty.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_scoreboard.sv | 63 ++++++
 rtl/pipe_hazard_sched.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard scheduler: FSM state encodings,
// default scoreboard latency and register-file geometry.
package pipe_ctrl_pkg;

  // Run/drain/done sequencing; the encodings are visible on out_state.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Cycles a consumer waits behind its producer (EX, MEM, WB).
  localparam int WB_LAT_DEFAULT = 3;

  // Architectural register file geometry.
  localparam int NREG_DEFAULT = 32;
  localparam int REG_AW       = 5;

  // The per-register countdown only ever needs to hold 0..3.
  localparam int CNT_W = 2;

  // r0 is hardwired and never tracked as busy.
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_scoreboard.sv
// Register scoreboard: one small down-counter per architectural register.
// A register is busy while its counter is nonzero. An issue reloads the
// destination counter with WB_LAT, otherwise every nonzero counter counts down.
// Two combinational busy lookups serve the rs/rt operands of the instruction
// in ID, and all_idle reports that no write is still in flight.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int WB_LAT = WB_LAT_DEFAULT,
  parameter int NREG   = NREG_DEFAULT
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_issue,
  input  logic [REG_AW-1:0] in_issue_addr,
  input  logic [REG_AW-1:0] in_rs_addr,
  input  logic [REG_AW-1:0] in_rt_addr,
  output logic              out_rs_busy,
  output logic              out_rt_busy,
  output logic              out_all_idle
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(WB_LAT);

  logic [CNT_W-1:0] r_cnt [NREG];

  // Counter update: issue reload wins over the per-cycle decrement; r0 pinned to 0.
  // NOTE: every counter is reset, not just the state register -- a stale
  // nonzero count after reset would show up as a phantom RAW stall.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_cnt[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        if (in_issue && (in_issue_addr == REG_AW'(i))) begin
          r_cnt[i] <= LAT;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Busy lookups for both operand ports plus the drained-pipeline flag.
  // NOTE: every output gets a default before the loop; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    out_rs_busy  = 1'b0;
    out_rt_busy  = 1'b0;
    out_all_idle = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      if (r_cnt[i] != '0) begin
        out_all_idle = 1'b0;
        if (in_rs_addr == REG_AW'(i)) out_rs_busy = 1'b1;
        if (in_rt_addr == REG_AW'(i)) out_rt_busy = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_sched.sv
// ID-stage hazard scheduler. A scoreboard of pending register writes drives
// the RAW stall; taken branches squash IF/ID; a RUN/DRAIN/DONE FSM freezes the
// front end on a halt request and reports when all in-flight writes retired.
// Optional build macro STALL_STATS_EN adds saturating stall-cycle and flush
// counters on out_stall_cycles / out_flush_count.
module pipe_hazard_sched
  import pipe_ctrl_pkg::*;
#(
  parameter int WB_LAT = WB_LAT_DEFAULT,
  parameter int NREG   = NREG_DEFAULT
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [REG_AW-1:0] in_rs_addr,
  input  logic [REG_AW-1:0] in_rt_addr,
  input  logic              in_rs_rena,
  input  logic              in_rt_rena,
  input  logic [REG_AW-1:0] in_rd_waddr,
  input  logic              in_rd_wena,
  input  logic              in_branch,
  input  logic              in_halt_req,
  input  logic              in_resume,
  output logic              out_stall,
  output logic              out_pc_ena,
  output logic              out_ifid_ena,
  output logic              out_ifid_flush,
  output logic              out_idex_bubble,
  output logic              out_halt_done,
  output logic [1:0]        out_state
`ifdef STALL_STATS_EN
  ,
  output logic [31:0]       out_stall_cycles,
  output logic [31:0]       out_flush_count
`endif
);

  state_e r_state;
  state_e w_state_nxt;
  logic   w_rs_busy;
  logic   w_rt_busy;
  logic   w_all_idle;
  logic   w_stall;
  logic   w_issue;

  // A RAW hazard exists when an operand actually read by ID is still pending.
  assign w_stall = (in_rs_rena & w_rs_busy) | (in_rt_rena & w_rt_busy);

  // Only RUN issues. An instruction held in ID during the halt cycle may still
  // mark its destination; that merely lengthens the drain and is harmless.
  assign w_issue = (r_state == ST_RUN) & ~w_stall & in_rd_wena &
                   (in_rd_waddr != REG_ZERO);

  pipe_scoreboard #(
    .WB_LAT (WB_LAT),
    .NREG   (NREG)
  ) u_sb (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_issue      (w_issue),
    .in_issue_addr (in_rd_waddr),
    .in_rs_addr    (in_rs_addr),
    .in_rt_addr    (in_rt_addr),
    .out_rs_busy   (w_rs_busy),
    .out_rt_busy   (w_rt_busy),
    .out_all_idle  (w_all_idle)
  );

  // State register with synchronous reset back to RUN.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge in_clk) begin
    if (in_rst) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state and front-end control; defaults describe a frozen front end.
  always_comb begin
    w_state_nxt     = r_state;
    out_pc_ena      = 1'b0;
    out_ifid_ena    = 1'b0;
    out_ifid_flush  = 1'b0;
    out_idex_bubble = 1'b1;
    out_halt_done   = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (in_halt_req) begin
          // Halt beats a same-cycle branch: no flush, ID instruction bubbled.
          w_state_nxt = ST_DRAIN;
        end else begin
          out_pc_ena      = ~w_stall;
          out_ifid_ena    = ~w_stall;
          out_idex_bubble = w_stall;
          // A branch waiting on busy operands is acted on once the stall clears.
          out_ifid_flush  = in_branch & ~w_stall;
        end
      end
      ST_DRAIN: begin
        if (w_all_idle) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_halt_done = 1'b1;
        // A halt request still present keeps the results parked in DONE.
        if (in_resume && !in_halt_req) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign out_stall = w_stall;
  assign out_state = r_state;

`ifdef STALL_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Saturating event counters for stall cycles in RUN and issued flushes.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if ((r_state == ST_RUN) && w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (out_ifid_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign out_stall_cycles = r_stall_cycles;
  assign out_flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Self-checking bench for pipe_hazard_sched. The reference model keeps, per
// register, the cycle number at which its pending write has retired, and
// derives busy/stall/FSM expectations from those timestamps every cycle.
// Build with STALL_STATS_EN defined to also exercise the statistics ports.
module tb_pipe_hazard_sched;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_addr, rt_addr, rd_waddr;
  logic       rs_rena, rt_rena, rd_wena, branch, halt_req, resume;
  logic       stall, pc_ena, ifid_ena, ifid_flush, idex_bubble, halt_done;
  logic [1:0] state;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  always #5 clk = ~clk;

  pipe_hazard_sched #(.WB_LAT(LAT), .NREG(32)) dut (
    .in_clk          (clk),
    .in_rst          (rst),
    .in_rs_addr      (rs_addr),
    .in_rt_addr      (rt_addr),
    .in_rs_rena      (rs_rena),
    .in_rt_rena      (rt_rena),
    .in_rd_waddr     (rd_waddr),
    .in_rd_wena      (rd_wena),
    .in_branch       (branch),
    .in_halt_req     (halt_req),
    .in_resume       (resume),
    .out_stall       (stall),
    .out_pc_ena      (pc_ena),
    .out_ifid_ena    (ifid_ena),
    .out_ifid_flush  (ifid_flush),
    .out_idex_bubble (idex_bubble),
    .out_halt_done   (halt_done),
    .out_state       (state)
`ifdef STALL_STATS_EN
    ,
    .out_stall_cycles (stall_cycles),
    .out_flush_count  (flush_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: ready[r] = first cycle at which r is no longer busy.
  int now = 0;
  int ready [32];
  int m_state = 0;          // 0 RUN, 1 DRAIN, 2 DONE
`ifdef STALL_STATS_EN
  logic [31:0] m_stall_cycles = '0;
  logic [31:0] m_flush_count  = '0;
`endif

  // Outputs observed in the most recent step, for directed checks.
  logic       last_stall, last_pc, last_ifid, last_flush, last_bubble, last_done;
  logic [1:0] last_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy(input int r);
    return (r != 0) && (ready[r] > now);
  endfunction

  function automatic bit m_idle();
    for (int r = 1; r < 32; r++) if (ready[r] > now) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: compare mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    bit e_stall, e_pc, e_bubble, e_flush, e_done, e_issue;
    #4;
    e_stall = (rs_rena && m_busy(int'(rs_addr))) || (rt_rena && m_busy(int'(rt_addr)));
    if (m_state == 0 && !halt_req) begin
      e_pc = !e_stall; e_bubble = e_stall; e_flush = branch && !e_stall;
    end else begin
      e_pc = 1'b0; e_bubble = 1'b1; e_flush = 1'b0;
    end
    e_done = (m_state == 2);
    last_stall = stall; last_pc = pc_ena; last_ifid = ifid_ena; last_flush = ifid_flush;
    last_bubble = idex_bubble; last_done = halt_done; last_state = state;
    chk($sformatf("c%0d stall", now), 32'(stall), 32'(e_stall));
    chk($sformatf("c%0d pc_ena", now), 32'(pc_ena), 32'(e_pc));
    chk($sformatf("c%0d ifid_ena", now), 32'(ifid_ena), 32'(e_pc));
    chk($sformatf("c%0d flush", now), 32'(ifid_flush), 32'(e_flush));
    chk($sformatf("c%0d bubble", now), 32'(idex_bubble), 32'(e_bubble));
    chk($sformatf("c%0d done", now), 32'(halt_done), 32'(e_done));
    chk($sformatf("c%0d state", now), 32'(state), 32'(m_state));
`ifdef STALL_STATS_EN
    chk($sformatf("c%0d stall_cycles", now), stall_cycles, m_stall_cycles);
    chk($sformatf("c%0d flush_count", now), flush_count, m_flush_count);
`endif
    @(posedge clk);
    if (rst) begin
      foreach (ready[r]) ready[r] = 0;
      m_state = 0;
`ifdef STALL_STATS_EN
      m_stall_cycles = '0;
      m_flush_count  = '0;
`endif
    end else begin
      e_issue = (m_state == 0) && !e_stall && rd_wena && (rd_waddr != 5'd0);
`ifdef STALL_STATS_EN
      if (m_state == 0 && e_stall && m_stall_cycles != 32'hFFFF_FFFF) m_stall_cycles++;
      if (e_flush && m_flush_count != 32'hFFFF_FFFF) m_flush_count++;
`endif
      case (m_state)
        0: if (halt_req) m_state = 1;
        1: if (m_idle()) m_state = 2;
        default: if (resume && !halt_req) m_state = 0;
      endcase
      if (e_issue) ready[int'(rd_waddr)] = now + LAT + 1;
    end
    now++;
    #1;
  endtask

  task automatic drive(input int rs, input bit rse, input int rt, input bit rte,
                       input int rd, input bit we, input bit br, input bit hr, input bit rsm);
    rs_addr = 5'(rs); rs_rena = rse; rt_addr = 5'(rt); rt_rena = rte;
    rd_waddr = 5'(rd); rd_wena = we; branch = br; halt_req = hr; resume = rsm;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  // Present a consumer of r8 and count the stall cycles before it issues.
  task automatic raw_len(output int n);
    n = 0;
    drive(8, 1, 0, 0, 9, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_stall) n++;
      else break;
    end
  endtask

  int n;

  initial begin
    foreach (ready[r]) ready[r] = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Post-reset output values.
    step();
    chk("rst_state", 32'(last_state), 32'd0);
    chk("rst_pc_ena", 32'(last_pc), 32'd1);
    chk("rst_ifid_ena", 32'(last_ifid), 32'd1);
    chk("rst_stall", 32'(last_stall), 32'd0);
    chk("rst_bubble", 32'(last_bubble), 32'd0);
    chk("rst_done", 32'(last_done), 32'd0);

    // Reset arriving mid-drain while r5 still has two cycles to go.
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; step();
    chk("t1_in_drain", 32'(last_state), 32'd1);
    rst = 1'b0;
    drive(5, 1, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t1_state_run", 32'(last_state), 32'd0);
    chk("t1_pc_ena", 32'(last_pc), 32'd1);
    chk("t1_r5_no_stall", 32'(last_stall), 32'd0);

    // Back-to-back RAW: three stall cycles, consumer issues on the fourth.
    idle(1);
    drive(0, 0, 0, 0, 8, 1, 0, 0, 0); step();
    raw_len(n);
    chk("t2_stall_len", 32'(n), 32'd3);
    chk("t2_issue_pc", 32'(last_pc), 32'd1);
    idle(4);
    // One independent instruction in between shortens the stall to two.
    drive(0, 0, 0, 0, 8, 1, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); step();
    raw_len(n);
    chk("t2_gap_stall_len", 32'(n), 32'd2);
    idle(4);

    // Writes to r0 never make it busy.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0); step();
    chk("t3_r0_stall", 32'(last_stall), 32'd0);
    chk("t3_cnt0", 32'(dut.u_sb.r_cnt[0]), 32'd0);

    // Branch without hazard flushes exactly one cycle.
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    chk("t4_flush", 32'(last_flush), 32'd1);
    idle(1);
    chk("t4_flush_off", 32'(last_flush), 32'd0);
    // Branch on a busy operand waits out the stall, then flushes once.
    drive(0, 0, 0, 0, 10, 1, 0, 0, 0); step();
    drive(10, 1, 0, 0, 0, 0, 1, 0, 0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_flush) break;
      n++;
    end
    chk("t4_flush_held", 32'(n), 32'd3);
    chk("t4_flush_late", 32'(last_flush), 32'd1);
    idle(1);
    chk("t4_flush_once", 32'(last_flush), 32'd0);

    // Halt with r3 in flight; the same-cycle branch must not flush.
    idle(3);
    drive(0, 0, 0, 0, 3, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0); step();
    chk("t5_halt_no_flush", 32'(last_flush), 32'd0);
    chk("t5_halt_bubble", 32'(last_bubble), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_state != 2'b01) break;
      n++;
      chk("t5_drain_bubble", 32'(last_bubble), 32'd1);
    end
    chk("t5_drain_len", 32'(n), 32'd3);
    chk("t5_done_state", 32'(last_state), 32'd2);
    chk("t5_halt_done", 32'(last_done), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("t5_halt_and_resume_stay", 32'(last_state), 32'd2);
    idle(1);
    chk("t5_resume_run", 32'(last_state), 32'd0);
    chk("t5_resume_pc", 32'(last_pc), 32'd1);

`ifdef STALL_STATS_EN
    // Counters from a clean reset: one three-cycle RAW stall plus one flush.
    rst = 1'b1; idle(1); rst = 1'b0;
    drive(0, 0, 0, 0, 8, 1, 0, 0, 0); step();
    raw_len(n);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    idle(1);
    chk("t6_stall_cycles", stall_cycles, 32'd3);
    chk("t6_flush_count", flush_count, 32'd1);
`endif

    // Randomized traffic over a small register window to provoke hazards.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 5),
            $urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 1),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) == 0));
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
